// File: rtl/pe_net_interface_if.sv
// Handshake bundle between a PE, its network interface, and one butterfly-tree leaf port.
// Signal names carry the direction as seen from the network interface (slave side).
interface pe_net_interface_if #(
    parameter int unsigned DataWidth = 36,
    parameter int unsigned AddrWidth = 4
);
    localparam int unsigned PayloadWidth = DataWidth - AddrWidth;

    // TX: PE -> interface -> network
    logic [PayloadWidth-1:0] i_pe_data;
    logic [AddrWidth-1:0]    i_pe_dest;
    logic                    i_pe_valid;
    logic                    o_pe_ready;
    logic [DataWidth-1:0]    o_data;
    logic                    o_data_valid;
    logic                    i_data_ready;

    // RX: network -> interface -> PE
    logic [DataWidth-1:0]    i_data;
    logic                    i_data_valid;
    logic                    o_data_ready;
    logic [PayloadWidth-1:0] o_pe_data;
    logic                    o_pe_valid;
    logic                    i_pe_ready;

    modport slave (
        input  i_pe_data, i_pe_dest, i_pe_valid, i_data_ready, i_data, i_data_valid, i_pe_ready,
        output o_pe_ready, o_data, o_data_valid, o_data_ready, o_pe_data, o_pe_valid
    );

    modport master (
        output i_pe_data, i_pe_dest, i_pe_valid, i_data_ready, i_data, i_data_valid, i_pe_ready,
        input  o_pe_ready, o_data, o_data_valid, o_data_ready, o_pe_data, o_pe_valid
    );
endinterface

// File: rtl/pe_net_interface.sv
// PE network interface: TX flit packing FIFO and RX address-filtering FIFO with a
// saturating misroute counter. Both FIFOs are first-word-fall-through, no full bypass.
module pe_net_interface #(
    parameter int unsigned DataWidth     = 36,
    parameter int unsigned AddrWidth     = 4,
    parameter int unsigned MyAddr        = 0,
    parameter int unsigned FifoDepthLog2 = 2   // legal 1..6
) (
    input  logic                     i_sclk,
    input  logic                     i_reset,
    pe_net_interface_if.slave        bus,
    output logic [FifoDepthLog2:0]   o_tx_level,
    output logic [FifoDepthLog2:0]   o_rx_level,
    output logic [7:0]               o_misroute_count
);
    localparam int unsigned PayloadWidth = DataWidth - AddrWidth;
    localparam int unsigned PtrW         = FifoDepthLog2;
    localparam int unsigned LvlW         = FifoDepthLog2 + 1;
    localparam int unsigned Depth        = 1 << FifoDepthLog2;
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

    logic [DataWidth-1:0]    tx_mem_q [Depth];
    logic [PayloadWidth-1:0] rx_mem_q [Depth];

    logic [PtrW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PtrW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [LvlW-1:0] tx_lvl_q, tx_lvl_d, rx_lvl_q, rx_lvl_d;
    logic [7:0]      mis_q, mis_d;
    // Holds both readys low during the first cycle after reset release.
    logic            run_q;

    logic tx_ready, tx_valid, tx_push, tx_pop;
    logic rx_ready, rx_valid, rx_accept, rx_match, rx_push, rx_drop, rx_pop;

    always_comb begin
        tx_ready  = run_q && (tx_lvl_q != DepthLvl);
        tx_valid  = (tx_lvl_q != '0);
        tx_push   = bus.i_pe_valid && tx_ready;
        tx_pop    = tx_valid && bus.i_data_ready;

        rx_ready  = run_q && (rx_lvl_q != DepthLvl);
        rx_valid  = (rx_lvl_q != '0);
        rx_accept = bus.i_data_valid && rx_ready;
        rx_match  = (bus.i_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
        rx_push   = rx_accept && rx_match;
        rx_drop   = rx_accept && !rx_match;
        rx_pop    = rx_valid && bus.i_pe_ready;
    end

    always_comb begin
        tx_wr_d  = tx_push ? tx_wr_q + PtrW'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + PtrW'(1) : tx_rd_q;
        tx_lvl_d = tx_lvl_q;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_lvl_d = tx_lvl_q + LvlW'(1);
            2'b01:   tx_lvl_d = tx_lvl_q - LvlW'(1);
            default: tx_lvl_d = tx_lvl_q;
        endcase

        rx_wr_d  = rx_push ? rx_wr_q + PtrW'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + PtrW'(1) : rx_rd_q;
        rx_lvl_d = rx_lvl_q;
        // A dropped flit never touches the level, so only push/pop matter here.
        unique case ({rx_push, rx_pop})
            2'b10:   rx_lvl_d = rx_lvl_q + LvlW'(1);
            2'b01:   rx_lvl_d = rx_lvl_q - LvlW'(1);
            default: rx_lvl_d = rx_lvl_q;
        endcase

        mis_d = (rx_drop && (mis_q != 8'hFF)) ? mis_q + 8'd1 : mis_q;
    end

    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_lvl_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_lvl_q <= '0;
            mis_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_lvl_q <= tx_lvl_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_lvl_q <= rx_lvl_d;
            mis_q    <= mis_d;
            run_q    <= 1'b1;
        end
    end

    // Storage needs no reset: the levels gate every read.
    always_ff @(posedge i_sclk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= {bus.i_pe_dest, bus.i_pe_data};
        if (rx_push) rx_mem_q[rx_wr_q] <= bus.i_data[PayloadWidth-1:0];
    end

    assign bus.o_pe_ready    = tx_ready;
    assign bus.o_data_valid  = tx_valid;
    assign bus.o_data        = tx_valid ? tx_mem_q[tx_rd_q] : '0;
    assign bus.o_data_ready  = rx_ready;
    assign bus.o_pe_valid    = rx_valid;
    assign bus.o_pe_data     = rx_valid ? rx_mem_q[rx_rd_q] : '0;
    assign o_tx_level        = tx_lvl_q;
    assign o_rx_level        = rx_lvl_q;
    assign o_misroute_count  = mis_q;
endmodule

// File: tb/tb_pe_net_interface.sv
// Bench for pe_net_interface: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pe_net_interface;
    localparam int unsigned DW = 36;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = DW - AW;
    localparam int unsigned MY = 2;
    localparam int unsigned D  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] tx_level, rx_level;
    logic [7:0] mis_count;

    int errors = 0;
    int checks = 0;

    pe_net_interface_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

    pe_net_interface #(
        .DataWidth(DW), .AddrWidth(AW), .MyAddr(MY), .FifoDepthLog2(2)
    ) dut (
        .i_sclk           (clk),
        .i_reset          (rst_n),
        .bus              (bus.slave),
        .o_tx_level       (tx_level),
        .o_rx_level       (rx_level),
        .o_misroute_count (mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, readys from occupancy and a started flag.
    logic [DW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    int            mcnt;
    bit            mrun;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txq.delete();
            rxq.delete();
            mcnt = 0;
            mrun = 1'b0;
        end else begin
            bit tx_rdy, rx_rdy;
            logic [DW-1:0] dtx;
            logic [PW-1:0] drx;
            tx_rdy = mrun && (txq.size() < D);
            rx_rdy = mrun && (rxq.size() < D);
            if (txq.size() != 0 && bus.i_data_ready) dtx = txq.pop_front();
            if (tx_rdy && bus.i_pe_valid) txq.push_back({bus.i_pe_dest, bus.i_pe_data});
            if (rxq.size() != 0 && bus.i_pe_ready) drx = rxq.pop_front();
            if (rx_rdy && bus.i_data_valid) begin
                if (bus.i_data[DW-1:PW] == AW'(MY)) rxq.push_back(bus.i_data[PW-1:0]);
                else if (mcnt < 255) mcnt++;
            end
            mrun = 1'b1;
        end
    end

    logic [DW-1:0] txlog[$];
    logic [PW-1:0] rxlog[$];

    always @(negedge clk) begin
        chk("tx_valid", 64'(bus.o_data_valid), 64'(txq.size() != 0));
        chk("tx_data", 64'(bus.o_data), (txq.size() != 0) ? 64'(txq[0]) : 64'd0);
        chk("tx_level", 64'(tx_level), 64'(txq.size()));
        chk("pe_ready", 64'(bus.o_pe_ready), 64'(mrun && txq.size() < D));
        chk("rx_valid", 64'(bus.o_pe_valid), 64'(rxq.size() != 0));
        chk("rx_data", 64'(bus.o_pe_data), (rxq.size() != 0) ? 64'(rxq[0]) : 64'd0);
        chk("rx_level", 64'(rx_level), 64'(rxq.size()));
        chk("data_ready", 64'(bus.o_data_ready), 64'(mrun && rxq.size() < D));
        chk("misroute", 64'(mis_count), 64'(mcnt));
        if (bus.o_data_valid && bus.i_data_ready) txlog.push_back(bus.o_data);
        if (bus.o_pe_valid && bus.i_pe_ready) rxlog.push_back(bus.o_pe_data);
    end

    // Inputs change 2 time units after each rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [DW-1:0] flit);
        bus.i_data       = flit;
        bus.i_data_valid = 1'b1;
        step();
    endtask

    initial begin
        bus.i_pe_data    = '0;
        bus.i_pe_dest    = '0;
        bus.i_pe_valid   = 1'b0;
        bus.i_data_ready = 1'b0;
        bus.i_data       = '0;
        bus.i_data_valid = 1'b0;
        bus.i_pe_ready   = 1'b0;

        // Reset state
        step(2);
        chk("rst_pe_ready", 64'(bus.o_pe_ready), 64'd0);
        chk("rst_data_ready", 64'(bus.o_data_ready), 64'd0);
        chk("rst_tx_level", 64'(tx_level), 64'd0);
        rst_n = 1'b1;
        chk("rel_pe_ready", 64'(bus.o_pe_ready), 64'd0);
        step();
        chk("rel1_pe_ready", 64'(bus.o_pe_ready), 64'd1);
        chk("rel1_data_ready", 64'(bus.o_data_ready), 64'd1);

        // TX ordering and 1-cycle latency
        bus.i_data_ready = 1'b1;
        bus.i_pe_valid   = 1'b1;
        bus.i_pe_dest    = 4'd5;
        bus.i_pe_data    = 32'h11;
        step();
        chk("tx_first_valid", 64'(bus.o_data_valid), 64'd1);
        chk("tx_first_data", 64'(bus.o_data), 64'h5_00000011);
        bus.i_pe_data = 32'h22;
        step();
        bus.i_pe_data = 32'h33;
        step();
        bus.i_pe_valid = 1'b0;
        step(3);
        chk("tx_seq_len", 64'(txlog.size()), 64'd3);
        if (txlog.size() == 3) begin
            chk("tx_seq0", 64'(txlog[0]), 64'h5_00000011);
            chk("tx_seq1", 64'(txlog[1]), 64'h5_00000022);
            chk("tx_seq2", 64'(txlog[2]), 64'h5_00000033);
        end
        txlog.delete();

        // TX full, no bypass
        bus.i_data_ready = 1'b0;
        bus.i_pe_valid   = 1'b1;
        bus.i_pe_dest    = 4'd1;
        for (int i = 0; i < 5; i++) begin
            bus.i_pe_data = 32'hA0 + 32'(i);
            step();
        end
        bus.i_pe_valid = 1'b0;
        chk("tx_full_level", 64'(tx_level), 64'd4);
        chk("tx_full_ready", 64'(bus.o_pe_ready), 64'd0);
        bus.i_data_ready = 1'b1;
        step();
        bus.i_data_ready = 1'b0;
        chk("tx_after_pop_level", 64'(tx_level), 64'd3);
        chk("tx_after_pop_ready", 64'(bus.o_pe_ready), 64'd1);
        bus.i_data_ready = 1'b1;
        step(4);
        chk("tx_full_len", 64'(txlog.size()), 64'd4);
        if (txlog.size() == 4) chk("tx_full_last", 64'(txlog[3]), 64'h1_000000A3);
        txlog.delete();

        // RX filtering
        bus.i_pe_ready = 1'b1;
        send(36'h2_000000AA);
        send(36'h7_000000BB);
        send(36'h2_000000CC);
        bus.i_data_valid = 1'b0;
        step(3);
        chk("rx_len", 64'(rxlog.size()), 64'd2);
        if (rxlog.size() == 2) begin
            chk("rx_first", 64'(rxlog[0]), 64'hAA);
            chk("rx_second", 64'(rxlog[1]), 64'hCC);
        end
        chk("rx_misroute1", 64'(mis_count), 64'd1);
        rxlog.delete();

        // RX backpressure, simultaneous push/pop, wrap-around
        bus.i_pe_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(36'h2_00000100 + 36'(i));
        bus.i_data_valid = 1'b0;
        chk("rx_full_ready", 64'(bus.o_data_ready), 64'd0);
        chk("rx_full_level", 64'(rx_level), 64'd4);
        bus.i_pe_ready = 1'b1;
        step(2);
        chk("rx_level2", 64'(rx_level), 64'd2);
        send(36'h2_00000105);
        chk("rx_pushpop_level", 64'(rx_level), 64'd2);
        for (int i = 0; i < 10; i++) begin
            bus.i_data       = 36'h2_00000110 + 36'(i);
            bus.i_data_valid = (i % 3) != 2;
            bus.i_pe_ready   = (i % 2) == 1;
            step();
        end
        bus.i_data_valid = 1'b0;
        bus.i_pe_ready   = 1'b1;
        step(6);
        chk("rx_wrap_len", 64'(rxlog.size()), 64'd11);
        if (rxlog.size() == 11) begin
            chk("rx_wrap_first", 64'(rxlog[0]), 64'h100);
            chk("rx_wrap_mid", 64'(rxlog[4]), 64'h105);
            chk("rx_wrap_last", 64'(rxlog[10]), 64'h119);
        end
        rxlog.delete();

        // Misroute saturation
        for (int i = 0; i < 300; i++) send(36'h7_00000000 + 36'(i));
        bus.i_data_valid = 1'b0;
        step();
        chk("misroute_sat", 64'(mis_count), 64'd255);

        // Asynchronous reset mid-stream
        bus.i_data_ready = 1'b0;
        bus.i_pe_ready   = 1'b0;
        bus.i_pe_valid   = 1'b1;
        bus.i_pe_dest    = 4'd3;
        for (int i = 0; i < 3; i++) begin
            bus.i_pe_data    = 32'h50 + 32'(i);
            bus.i_data       = 36'h2_00000200 + 36'(i);
            bus.i_data_valid = 1'b1;
            step();
        end
        bus.i_pe_valid   = 1'b0;
        bus.i_data_valid = 1'b0;
        chk("pre_rst_tx_level", 64'(tx_level), 64'd3);
        chk("pre_rst_rx_level", 64'(rx_level), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 64'(bus.o_data_valid), 64'd0);
        chk("arst_rx_valid", 64'(bus.o_pe_valid), 64'd0);
        chk("arst_tx_data", 64'(bus.o_data), 64'd0);
        chk("arst_rx_data", 64'(bus.o_pe_data), 64'd0);
        chk("arst_pe_ready", 64'(bus.o_pe_ready), 64'd0);
        chk("arst_data_ready", 64'(bus.o_data_ready), 64'd0);
        chk("arst_tx_level", 64'(tx_level), 64'd0);
        chk("arst_rx_level", 64'(rx_level), 64'd0);
        chk("arst_misroute", 64'(mis_count), 64'd0);
        step(2);
        rst_n = 1'b1;
        bus.i_data_ready = 1'b1;
        bus.i_pe_ready   = 1'b1;
        step(3);
        chk("post_rst_tx_level", 64'(tx_level), 64'd0);
        chk("post_rst_rx_level", 64'(rx_level), 64'd0);
        chk("post_rst_tx_valid", 64'(bus.o_data_valid), 64'd0);
        chk("post_rst_rx_valid", 64'(bus.o_pe_valid), 64'd0);
        chk("post_rst_txlog", 64'(txlog.size()), 64'd0);
        chk("post_rst_rxlog", 64'(rxlog.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
